// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the RV32 pipeline: word type, memory-stage states
// and the load/store funct3 encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } memstate_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte and halfword stores need the old word first (read-modify-write).
    function automatic logic is_subword_store(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response port between the memory stage and the cache.
interface mem_stage_if;
    import cpu_types_pkg::*;

    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dhit;
    word_t dload;

    modport master (
        output dREN,
        output dWEN,
        output daddr,
        output dstore,
        input  dhit,
        input  dload
    );

    modport slave (
        input  dREN,
        input  dWEN,
        input  daddr,
        input  dstore,
        output dhit,
        output dload
    );

endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module load_store_align
    import cpu_types_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  word_t      load_word,
    input  word_t      store_data,
    input  word_t      merge_base,
    output word_t      load_value,
    output word_t      merged_word
);

    logic [3:0][7:0] load_bytes;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [3:0]      byte_en;

    assign load_bytes = load_word;
    assign lane_byte  = load_bytes[addr_lo];
    assign lane_half  = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_value = load_word;
        case (funct3)
            F3_B:    load_value = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_value = {24'h0, lane_byte};
            F3_H:    load_value = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_value = {16'h0, lane_half};
            default: load_value = load_word;
        endcase
    end

    always_comb begin
        byte_en = 4'b1111;
        case (funct3)
            F3_B:    byte_en = 4'b0001 << addr_lo;
            F3_H:    byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Store data is replicated across lanes so each enabled lane picks its own copy.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] src_byte;

            always_comb begin
                src_byte = store_data[gi*8 +: 8];
                case (funct3)
                    F3_B:    src_byte = store_data[7:0];
                    F3_H:    src_byte = store_data[(gi % 2)*8 +: 8];
                    default: src_byte = store_data[gi*8 +: 8];
                endcase
            end

            assign merged_word[gi*8 +: 8] = byte_en[gi] ? src_byte : merge_base[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: sequences data-cache reads/writes (with RMW for SB/SH),
// stalls upstream while busy and registers the aligned load result for MEM/WB.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN_ex,
    input  logic        dWEN_ex,
    input  logic [2:0]  funct3_ex,
    input  word_t       presult_ex,
    input  word_t       store_ex,
    input  logic        advance,
    mem_stage_if.master dcache,
    output word_t       dmemload_mem,
    output word_t       presult_mem,
    output logic        mem_busy,
    output logic        mem_done
);

    memstate_t state_reg;
    memstate_t state_next;
    word_t     rdata_q;
    word_t     load_value;
    word_t     merged_word;
    logic      sub_store;
    logic      load_op;

    // EX/MEM is frozen by mem_busy, so the op can be decoded from its outputs throughout.
    assign sub_store = dWEN_ex & is_subword_store(funct3_ex);
    assign load_op   = dREN_ex & ~dWEN_ex;

    load_store_align u_align (
        .funct3      (funct3_ex),
        .addr_lo     (presult_ex[1:0]),
        .load_word   (dcache.dload),
        .store_data  (store_ex),
        .merge_base  (rdata_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            rdata_q      <= '0;
            dmemload_mem <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == READ && dcache.dhit) begin
                rdata_q <= dcache.dload;
                if (load_op) begin
                    dmemload_mem <= load_value;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (dWEN_ex) begin
                    state_next = sub_store ? READ : WRITE;
                end else if (dREN_ex) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (dcache.dhit) begin
                    state_next = sub_store ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (dcache.dhit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (advance) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dcache.dREN   = (state_reg == READ);
    assign dcache.dWEN   = (state_reg == WRITE);
    assign dcache.daddr  = {presult_ex[31:2], 2'b00};
    assign dcache.dstore = sub_store ? merged_word : store_ex;

    assign presult_mem = presult_ex;
    assign mem_done    = (state_reg == DONE);
    assign mem_busy    = (state_reg == READ) || (state_reg == WRITE) ||
                         ((state_reg == IDLE) && (dREN_ex || dWEN_ex));

endmodule
